// File: rtl/up_cntr_monitor.sv
// up_cntr_monitor
//   Checker that watches a free-running up counter and locks onto its
//   +1 mod 2^WIDTH sequence. Once locked it counts max->0 wraps, pulses a
//   terminal-count strobe and flags skipped, held or reversed counts.
//
// Ports
//   clk       system clock, all state on the rising edge
//   rst       asynchronous active-low reset, clears every register
//   en        monitor enable; low forces IDLE (error/wrap history is kept)
//   q         counter value under observation
//   clr_err   synchronous clear of err / err_cnt (a same-cycle error wins)
//   locked    high while the checker is in LOCK
//   tc        one-cycle pulse after the maximum count is sampled in LOCK
//   err       sticky error flag
//   err_cnt   saturating error count
//   wrap_cnt  number of max->0 transitions seen in LOCK (wraps)
//   last_bad  q value that caused the most recent error
module up_cntr_monitor #(
  parameter int WIDTH    = 3,
  parameter int SYNC_CNT = 2,
  parameter int WRAP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  q,
  input  logic              clr_err,
  output logic              locked,
  output logic              tc,
  output logic              err,
  output logic [7:0]        err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [WIDTH-1:0]  last_bad
);

  localparam logic [WIDTH-1:0]  Q_MAX    = '1;
  localparam logic [WIDTH-1:0]  Q_ONE    = WIDTH'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
  localparam logic [3:0]        SYNC_L   = 4'(SYNC_CNT);

  typedef enum logic [1:0] {IDLE, SYNC, LOCK, FAULT} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] q_prev;
  logic [3:0]       good;
  logic [3:0]       good_nxt;
  logic [3:0]       good_inc;
  logic [WIDTH-1:0] exp_q;
  logic             hit;
  logic             bad;
  logic             wrap_hit;
  logic             tc_nxt;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

  assign exp_q    = q_prev + Q_ONE;
  assign hit      = (q == exp_q);
  assign good_inc = good + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    bad       = 1'b0;
    wrap_hit  = 1'b0;
    tc_nxt    = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          state_nxt = SYNC;
          good_nxt  = 4'd0;
        end
        // FAULT lasts one cycle but its sample already counts toward the
        // resync, so a clean count relocks SYNC_CNT good samples after the
        // bad one.
        SYNC, FAULT: begin
          if (hit) begin
            good_nxt  = good_inc;
            state_nxt = (good_inc == SYNC_L) ? LOCK : SYNC;
          end else begin
            good_nxt  = 4'd0;
            state_nxt = SYNC;
          end
        end
        LOCK: begin
          tc_nxt = (q == Q_MAX);
          if (hit) begin
            wrap_hit = (q_prev == Q_MAX);
          end else begin
            bad       = 1'b1;
            good_nxt  = 4'd0;
            state_nxt = FAULT;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_prev   <= '0;
      good     <= 4'd0;
      locked   <= 1'b0;
      tc       <= 1'b0;
      err      <= 1'b0;
      err_cnt  <= 8'd0;
      wrap_cnt <= '0;
      last_bad <= '0;
    end else begin
      if (en) q_prev <= q;
      good   <= good_nxt;
      locked <= (state_nxt == LOCK);
      tc     <= tc_nxt;
      if (wrap_hit) wrap_cnt <= wrap_cnt + WRAP_ONE;
      // A new error beats a simultaneous clear: the count restarts at 1.
      if (bad) begin
        err      <= 1'b1;
        err_cnt  <= clr_err ? 8'd1 : sat_inc(err_cnt);
        last_bad <= q;
      end else if (clr_err) begin
        err     <= 1'b0;
        err_cnt <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_up_cntr_monitor.sv
module tb_up_cntr_monitor;

  localparam int WIDTH    = 3;
  localparam int SYNC_CNT = 2;
  localparam int WRAP_W   = 8;

  localparam int S_IDLE  = 0;
  localparam int S_SYNC  = 1;
  localparam int S_LOCK  = 2;
  localparam int S_FAULT = 3;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [WIDTH-1:0]  q = '0;
  logic              clr_err = 1'b0;
  logic              locked;
  logic              tc;
  logic              err;
  logic [7:0]        err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;
  logic [WIDTH-1:0]  last_bad;

  int checks = 0;
  int errors = 0;

  logic [31:0] sb_q[$];

  // reference model state
  int       m_st;
  int       m_good;
  int       m_qprev;
  bit       m_locked;
  bit       m_tc;
  bit       m_err;
  int       m_errcnt;
  int       m_wrap;
  int       m_lastbad;

  up_cntr_monitor #(.WIDTH(WIDTH), .SYNC_CNT(SYNC_CNT), .WRAP_W(WRAP_W)) dut (
    .clk(clk), .rst(rst), .en(en), .q(q), .clr_err(clr_err),
    .locked(locked), .tc(tc), .err(err), .err_cnt(err_cnt),
    .wrap_cnt(wrap_cnt), .last_bad(last_bad)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, expv);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return {10'd0, locked, tc, err, err_cnt, wrap_cnt, last_bad};
  endfunction

  function automatic logic [31:0] model_outs();
    logic [31:0] v;
    v = {10'd0, m_locked, m_tc, m_err, 8'(m_errcnt), 8'(m_wrap), 3'(m_lastbad)};
    return v;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_good = 0; m_qprev = 0; m_locked = 0; m_tc = 0;
    m_err = 0; m_errcnt = 0; m_wrap = 0; m_lastbad = 0;
  endtask

  task automatic model_step(input bit e, input int qi, input bit c);
    int  ex;
    bit  bad;
    ex  = (m_qprev + 1) % 8;
    bad = 0;
    m_tc = 0;
    if (!e) begin
      m_st = S_IDLE;
    end else if (m_st == S_IDLE) begin
      m_st = S_SYNC;
      m_good = 0;
    end else if (m_st == S_SYNC || m_st == S_FAULT) begin
      if (qi == ex) begin
        m_good = m_good + 1;
        m_st = (m_good == SYNC_CNT) ? S_LOCK : S_SYNC;
      end else begin
        m_good = 0;
        m_st = S_SYNC;
      end
    end else begin
      m_tc = (qi == 7);
      if (qi == ex) begin
        if (m_qprev == 7) m_wrap = (m_wrap + 1) % 256;
      end else begin
        bad = 1;
        m_good = 0;
        m_st = S_FAULT;
      end
    end
    if (bad) begin
      m_err = 1;
      m_errcnt = c ? 1 : ((m_errcnt < 255) ? m_errcnt + 1 : 255);
      m_lastbad = qi;
    end else if (c) begin
      m_err = 0;
      m_errcnt = 0;
    end
    if (e) m_qprev = qi;
    m_locked = (m_st == S_LOCK);
  endtask

  // Drive one sample, predict the post-edge outputs, then compare.
  task automatic step(input bit e, input int qi, input bit c);
    logic [31:0] expv;
    @(negedge clk);
    en = e;
    q = 3'(qi);
    clr_err = c;
    model_step(e, qi, c);
    sb_q.push_back(model_outs());
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      expv = sb_q.pop_front();
      check("outs", dut_outs(), expv);
    end
  endtask

  initial begin
    int v;
    model_reset();
    #1 rst = 1'b0;
    #1 check("reset_outs", dut_outs(), 32'd0);
    #1 rst = 1'b1;

    // clean count from 0 through one wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b1, i % 8, 1'b0);
      if (i == 1) check("lock_pre", 32'(locked), 32'd0);
      if (i == 2) check("lock_q2", 32'(locked), 32'd1);
      if (i == 7) check("tc_q7", 32'(tc), 32'd1);
      if (i == 8) begin
        check("tc_clear", 32'(tc), 32'd0);
        check("wrap_1", 32'(wrap_cnt), 32'd1);
      end
    end
    check("err_none", 32'(err), 32'd0);

    // skipped count: 5 where 4 expected
    step(1'b1, 2, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 5, 1'b0);
    check("skip_err", 32'(err), 32'd1);
    check("skip_cnt", 32'(err_cnt), 32'd1);
    check("skip_last", 32'(last_bad), 32'd5);
    check("skip_unlock", 32'(locked), 32'd0);
    step(1'b1, 6, 1'b0);
    check("resync_6", 32'(locked), 32'd0);
    step(1'b1, 7, 1'b0);
    check("relock_7", 32'(locked), 32'd1);
    check("tc_not_locked", 32'(tc), 32'd0);

    // clr_err alone
    step(1'b1, 0, 1'b1);
    check("clr_err", 32'(err), 32'd0);
    check("clr_cnt", 32'(err_cnt), 32'd0);

    // held count
    step(1'b1, 1, 1'b0);
    step(1'b1, 2, 1'b0);
    step(1'b1, 3, 1'b0);
    step(1'b1, 3, 1'b0);
    check("hold_cnt", 32'(err_cnt), 32'd1);
    check("hold_last", 32'(last_bad), 32'd3);
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b0);
    check("hold_relock", 32'(locked), 32'd1);

    // error and clear in the same cycle: error wins
    step(1'b1, 6, 1'b0);
    step(1'b1, 6, 1'b1);
    check("clr_vs_err", 32'(err), 32'd1);
    check("clr_vs_err_cnt", 32'(err_cnt), 32'd1);
    step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b0);
    check("relock_0", 32'(locked), 32'd1);

    // 300 forced errors, each followed by a resync
    v = 0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, v, 1'b0);
      step(1'b1, (v + 1) % 8, 1'b0);
      step(1'b1, (v + 2) % 8, 1'b0);
      v = (v + 2) % 8;
    end
    check("sat_cnt", 32'(err_cnt), 32'd255);
    check("sat_err", 32'(err), 32'd1);

    // one more wrap while locked
    for (int i = 1; i <= 8; i++) step(1'b1, (v + i) % 8, 1'b0);
    check("wrap_3", 32'(wrap_cnt), 32'd3);

    // enable dropped for 4 cycles
    for (int i = 0; i < 4; i++) step(1'b0, $urandom_range(0, 7), 1'b0);
    check("en_off_lock", 32'(locked), 32'd0);
    check("en_off_wrap", 32'(wrap_cnt), 32'd3);
    check("en_off_errcnt", 32'(err_cnt), 32'd255);
    step(1'b1, 4, 1'b0);
    step(1'b1, 5, 1'b0);
    check("en_on_pre", 32'(locked), 32'd0);
    step(1'b1, 6, 1'b0);
    check("en_on_lock", 32'(locked), 32'd1);

    // asynchronous reset in the middle of a count
    step(1'b1, 7, 1'b0);
    step(1'b1, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    en = 1'b0;
    #1 check("rst_async", dut_outs(), 32'd0);
    model_reset();
    #1 rst = 1'b1;
    step(1'b1, 0, 1'b0);
    step(1'b1, 1, 1'b0);
    check("rst_pre_lock", 32'(locked), 32'd0);
    step(1'b1, 2, 1'b0);
    check("rst_relock", 32'(locked), 32'd1);
    check("rst_wrap0", 32'(wrap_cnt), 32'd0);
    for (int i = 3; i <= 8; i++) step(1'b1, i % 8, 1'b0);
    check("rst_wrap1", 32'(wrap_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
